// File: rtl/bk_pipe_addsub.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready stream handshake.
// Prefix levels are evenly split into PIPE_STAGES register ranks, followed by one output rank.
module bk_pipe_addsub #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             carryin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LG   = $clog2(WIDTH);
  localparam int NLEV = 2 * LG - 1;

  // g/pp evolve through the tree; p is the raw propagate kept for the final xor.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] p;
    logic             c0;
    logic [TAG_W-1:0] tag;
  } rank_t;

  // Level s < LG is up-sweep span 2^s; the rest are down-sweep levels in decreasing span.
  function automatic rank_t bk_level(input rank_t r, input int s);
    rank_t n;
    int    d;
    int    j;
    n = r;
    d = (s < LG) ? (1 << s) : (1 << (2 * LG - 2 - s));
    for (int i = 0; i < WIDTH; i++) begin
      j = -1;
      if (s < LG) begin
        if ((i + 1) % (2 * d) == 0) j = i - d;
      end else if ((i + 1) > 2 * d && (i + 1) % (2 * d) == d) begin
        j = i - d;
      end
      if (j >= 0) begin
        n.g[i]  = r.g[i] | (r.pp[i] & r.g[j]);
        n.pp[i] = r.pp[i] & r.pp[j];
      end
    end
    return n;
  endfunction

  logic             stall;
  logic [WIDTH-1:0] b_eff, p_in, g_in, carries, sum_n;
  logic             c0_in;
  rank_t            st [NLEV+1];
  logic [NLEV:0]    vld_pipe;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign b_eff = sub ? ~inputB : inputB;
  assign c0_in = sub | carryin;
  assign p_in  = inputA ^ b_eff;
  assign g_in  = inputA & b_eff;

  // Carry-in folded into bit 0 so every prefix g[i] is directly the carry out of bit i.
  assign st[0] = {g_in | {{(WIDTH-1){1'b0}}, p_in[0] & c0_in}, p_in, p_in, c0_in, in_tag};
  assign vld_pipe[0] = in_valid & in_ready;

  for (genvar s = 0; s < NLEV; s++) begin : g_lvl
    rank_t nxt;
    assign nxt = bk_level(st[s], s);
    if (((s + 1) * PIPE_STAGES) / NLEV != (s * PIPE_STAGES) / NLEV) begin : g_reg
      rank_t q;
      logic  v;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
          v <= 1'b0;
        end else if (!stall) begin
          q <= nxt;
          v <= vld_pipe[s];
        end
      end
      assign st[s+1]       = q;
      assign vld_pipe[s+1] = v;
    end else begin : g_comb
      assign st[s+1]       = nxt;
      assign vld_pipe[s+1] = vld_pipe[s];
    end
  end

  assign carries = {st[NLEV].g[WIDTH-2:0], st[NLEV].c0};
  assign sum_n   = st[NLEV].p ^ carries;

  // Result registers only load on a valid op so they keep their last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carryOut  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= vld_pipe[NLEV];
      if (vld_pipe[NLEV]) begin
        sum      <= sum_n;
        carryOut <= st[NLEV].g[WIDTH-1];
        overflow <= st[NLEV].g[WIDTH-1] ^ st[NLEV].g[WIDTH-2];
        zero     <= ~|sum_n;
        out_tag  <= st[NLEV].tag;
      end
    end
  end

endmodule

// File: tb/tb_bk_pipe_addsub.sv
// Directed bench for bk_pipe_addsub (WIDTH=32, PIPE_STAGES=2): single ops, streams, stalls, reset flush.
module tb_bk_pipe_addsub;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  inputA = '0, inputB = '0;
  logic          carryin = 1'b0, sub = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid, out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          carryOut, overflow, zero;
  logic [TW-1:0] out_tag;

  int n_chk = 0;
  int n_err = 0;

  bk_pipe_addsub #(.WIDTH(W), .PIPE_STAGES(2), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inputA(inputA), .inputB(inputB), .carryin(carryin), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carryOut(carryOut),
    .overflow(overflow), .zero(zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {signed overflow, carry out, sum}; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         o;
    bb = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : cin)};
    o  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {o, r};
  endfunction

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sb, input logic [TW-1:0] tg, input logic [W-1:0] es,
                         input logic ec, input logic eo, input logic ez);
    int lat;
    inputA = a; inputB = b; carryin = cin; sub = sb; in_tag = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    chk("sum", 64'(sum), 64'(es));
    chk("carryOut", 64'(carryOut), 64'(ec));
    chk("overflow", 64'(overflow), 64'(eo));
    chk("zero", 64'(zero), 64'(ez));
    chk("tag", 64'(out_tag), 64'(tg));
    @(posedge clk); #1;
    chk("drain", 64'(out_valid), 64'd0);
  endtask

  task automatic gen_op(input int k);
    inputA  = 32'h9E3779B9 * 32'(k + 3);
    inputB  = {inputA[15:0], inputA[31:16]} ^ 32'(k * 77);
    sub     = k[0];
    carryin = k[1];
    if (k % 5 == 4) begin
      inputB = inputA;
      sub    = 1'b1;
    end
    in_tag = TW'(k);
  endtask

  task automatic stream(input int nops, input int stall_lo, input int stall_hi,
                        input bit bubbles, input bit lat_chk);
    logic [W+TW+1:0] q[$];
    int              qc[$];
    logic [W+TW+1:0] e;
    logic [W+1:0]    m;
    logic [W-1:0]    hsum;
    logic [TW-1:0]   htag;
    bit              held, fire_in, fire_out;
    int              sent, got, cyc;
    sent = 0; got = 0; cyc = 0; held = 0; hsum = '0; htag = '0;
    while (got < nops && cyc < nops + 60) begin
      in_valid  = (sent < nops) && !(bubbles && (cyc % 3 == 2));
      gen_op(sent);
      out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      #1;
      if (!out_ready && out_valid) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (held) begin
          chk("hold_sum", 64'(sum), 64'(hsum));
          chk("hold_tag", 64'(out_tag), 64'(htag));
        end
        held = 1; hsum = sum; htag = out_tag;
      end else begin
        held = 0;
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("s_sum", 64'(sum), 64'(e[W-1:0]));
          chk("s_cout", 64'(carryOut), 64'(e[W]));
          chk("s_ovf", 64'(overflow), 64'(e[W+1]));
          chk("s_zero", 64'(zero), 64'(e[W-1:0] == '0));
          chk("s_tag", 64'(out_tag), 64'(e[W+TW+1:W+2]));
          if (lat_chk) chk("s_latency", 64'(cyc - qc.pop_front()), 64'd3);
          else void'(qc.pop_front());
        end
        got++;
      end
      if (fire_in) begin
        m = model(inputA, inputB, carryin, sub);
        q.push_back({in_tag, m});
        qc.push_back(cyc);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_count", 64'(got), 64'(nops));
    chk("stream_leftover", 64'(q.size()), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({carryOut, overflow, zero}), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_one(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_one(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h2, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_one(32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'h3, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_one(32'h00000005, 32'h00000005, 1'b1, 1'b1, 4'h4, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_one(32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'h5, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_one(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'h6, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_one(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 4'h7, 32'hACF13568, 1'b0, 1'b0, 1'b0);
    run_one(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 4'h8, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_one(32'h00000000, 32'h00000001, 1'b0, 1'b1, 4'h9, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

    stream(8, -1, -1, 1'b0, 1'b1);
    stream(12, 5, 10, 1'b0, 1'b0);
    stream(16, 7, 10, 1'b1, 1'b0);

    // Reset with three ops in flight: none of them may ever come out.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inputA = 32'(k + 1); inputB = 32'd10; carryin = 1'b0; sub = 1'b0;
      in_tag = TW'(10 + k); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_sum", 64'(sum), 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flushed_ops", 64'(seen), 64'd0);
    run_one(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 4'hF, 32'h00010000, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
